apb_multi_master_bridge: RTL and testbench

Parametrised APB requester-side bridge: accepts single read/write requests on a valid/ready command port, decodes the target slave from the upper address bits, and drives an APB SETUP/ACCESS sequence to one of `NUM_SLAVES` completers. It is the successor to the fixed two-slave, 9-bit-address, 8-bit-data APB master used in the current protocol top. It adds wait states via `PREADY`, per-slave `PSLVERR`, an access timeout, out-of-range decode errors, and back-to-back transfers. The bridge sits between the system-side transaction source and the APB slave array.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_multi_master_bridge_if.sv | 39 +++
 rtl/apb_slave_decode.sv | 39 +++
 rtl/apb_multi_master_bridge.sv | 103 ++++++++++
 tb/tb_apb_multi_master_bridge.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester bridge.
// Legacy defaults match the old fixed two-slave, 9-bit address, 8-bit data master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DERR
    } apb_state_e;

    localparam int LEGACY_ADDR_W     = 9;
    localparam int LEGACY_DATA_W     = 8;
    localparam int LEGACY_NUM_SLAVES = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_multi_master_bridge_if.sv
// Command/response port plus APB completer bus of the bridge.
// The master modport is the bridge side; slave is the system and completer side.
interface apb_multi_master_bridge_if
    import apb_pkg::*;
#(
    parameter int ADDR_W     = LEGACY_ADDR_W,
    parameter int DATA_W     = LEGACY_DATA_W,
    parameter int NUM_SLAVES = LEGACY_NUM_SLAVES
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [ADDR_W-1:0]            req_addr;
    logic [DATA_W-1:0]            req_wdata;
    logic                         rsp_valid;
    logic [DATA_W-1:0]            rsp_rdata;
    logic                         rsp_err;
    logic [NUM_SLAVES-1:0]        PSEL;
    logic                         PENABLE;
    logic                         PWRITE;
    logic [ADDR_W-1:0]            PADDR;
    logic [DATA_W-1:0]            PWDATA;
    logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]        PREADY;
    logic [NUM_SLAVES-1:0]        PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_slave_decode.sv
// Address-to-completer decode for incoming requests, and the read-data/ready/error
// mux for the completer currently latched in sel_idx.
module apb_slave_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W     = LEGACY_ADDR_W,
    parameter int DATA_W     = LEGACY_DATA_W,
    parameter int NUM_SLAVES = LEGACY_NUM_SLAVES,
    parameter int SEL_W      = 1
) (
    input  logic [ADDR_W-1:0]            addr,
    input  logic [SEL_W-1:0]             sel_idx,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr,
    output logic [SEL_W-1:0]             idx,
    output logic                         out_of_range,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic                         slverr
);
    assign idx          = addr[ADDR_W-1 -: SEL_W];
    assign out_of_range = {1'b0, idx} >= (SEL_W + 1)'(NUM_SLAVES);

    // Loop compare keeps the slice in bounds; non-selected completers are invisible.
    always_comb begin
        rdata  = '0;
        ready  = 1'b0;
        slverr = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_idx == SEL_W'(k)) begin
                rdata  = prdata[k*DATA_W +: DATA_W];
                ready  = pready[k];
                slverr = pslverr[k];
            end
        end
    end

endmodule

// File: rtl/apb_multi_master_bridge.sv
// APB requester bridge: one request at a time, SETUP/ACCESS with wait states,
// access timeout, decode errors and back-to-back transfers.
module apb_multi_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W     = LEGACY_ADDR_W,
    parameter int DATA_W     = LEGACY_DATA_W,
    parameter int NUM_SLAVES = LEGACY_NUM_SLAVES,
    parameter int TIMEOUT    = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    apb_multi_master_bridge_if.master bus
);
    localparam int SEL_W = (clog2(NUM_SLAVES) > 1) ? clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e        state;
    logic [SEL_W-1:0]  sel_idx;
    logic [SEL_W-1:0]  dec_idx;
    logic [CNT_W-1:0]  tcnt;
    logic              dec_oor;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              done;
    logic              accept;

    apb_slave_decode #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .SEL_W(SEL_W)
    ) u_dec (
        .addr(bus.req_addr), .sel_idx(sel_idx), .prdata(bus.PRDATA),
        .pready(bus.PREADY), .pslverr(bus.PSLVERR), .idx(dec_idx),
        .out_of_range(dec_oor), .rdata(sel_rdata), .ready(sel_ready), .slverr(sel_err)
    );

    // A ready completer wins over a timeout landing in the same cycle.
    assign done          = (state == ACCESS) && (sel_ready || tcnt == CNT_LAST);
    assign bus.req_ready = (state == IDLE) || done;
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state         <= IDLE;
            sel_idx       <= '0;
            tcnt          <= '0;
            bus.PSEL      <= '0;
            bus.PENABLE   <= 1'b0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: ;
                SETUP: begin
                    state       <= ACCESS;
                    bus.PENABLE <= 1'b1;
                    tcnt        <= '0;
                end
                ACCESS: begin
                    if (done) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= sel_ready ? sel_err : 1'b1;
                        bus.rsp_rdata <= (sel_ready && !bus.PWRITE && !sel_err) ? sel_rdata : '0;
                        state         <= IDLE;
                        bus.PSEL      <= '0;
                        bus.PENABLE   <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DERR: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_rdata <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A new request overrides the completion's return to IDLE.
            if (accept) begin
                bus.PADDR   <= bus.req_addr;
                bus.PWRITE  <= bus.req_write;
                bus.PWDATA  <= bus.req_wdata;
                sel_idx     <= dec_idx;
                bus.PENABLE <= 1'b0;
                if (dec_oor) begin
                    state    <= DERR;
                    bus.PSEL <= '0;
                end else begin
                    state    <= SETUP;
                    bus.PSEL <= NUM_SLAVES'(1) << dec_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_multi_master_bridge.sv
// Bench for the APB bridge: legacy 9/8/2 instance with TIMEOUT=4 and a
// 10/8/3 instance for decode errors, checked against a transaction-level model.
module tb_apb_multi_master_bridge;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int   a_wait;
    bit   a_err;
    int   a_acnt;

    apb_multi_master_bridge_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2)) a_if ();
    apb_multi_master_bridge_if #(.ADDR_W(10), .DATA_W(8), .NUM_SLAVES(3)) b_if ();

    apb_multi_master_bridge #(.ADDR_W(9), .DATA_W(8), .NUM_SLAVES(2), .TIMEOUT(4)) dut_a (
        .PCLK(clk), .PRESETn(rst_n), .bus(a_if)
    );
    apb_multi_master_bridge #(.ADDR_W(10), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(16)) dut_b (
        .PCLK(clk), .PRESETn(rst_n), .bus(b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completer model for instance A: selected slave is ready after a_wait wait
    // states; non-selected slaves toggle PREADY randomly and always flag an error.
    always @(negedge clk) begin
        if (a_if.PSEL != '0 && a_if.PENABLE) a_acnt++;
        else a_acnt = 0;
        for (int k = 0; k < 2; k++) begin
            a_if.PREADY[k]  = a_if.PSEL[k] ? (a_acnt > a_wait) : 1'($urandom_range(0, 1));
            a_if.PSLVERR[k] = a_if.PSEL[k] ? a_err : 1'b1;
        end
    end

    // Transaction-level expectation for instance A (TIMEOUT=4).
    function automatic void model_a(input bit wr, input logic [8:0] addr, input int w, input bit e,
                                    input logic [15:0] prd, output int lat, output int acc,
                                    output logic [1:0] sel, output bit err, output logic [7:0] rd);
        int idx;
        idx = int'(addr >> 8);
        sel = 2'(1 << idx);
        if (w >= 4) begin
            acc = 4; err = 1'b1; rd = 8'h00;
        end else begin
            acc = w + 1; err = e;
            rd  = (!wr && !e) ? prd[idx*8 +: 8] : 8'h00;
        end
        lat = acc + 2;
    endfunction

    task automatic a_xfer(input bit wr, input logic [8:0] addr, input logic [7:0] wd, input int w,
                          input bit e, input logic [15:0] prd, output int lat, output int acc,
                          output int selc, output logic [1:0] sel, output bit err,
                          output logic [7:0] rd, output int bad_hold);
        lat = -1; acc = 0; selc = 0; sel = '0; err = 1'b0; rd = '0; bad_hold = 0;
        @(negedge clk);
        a_wait = w; a_err = e; a_if.PRDATA = prd;
        a_if.req_valid = 1'b1; a_if.req_write = wr; a_if.req_addr = addr; a_if.req_wdata = wd;
        @(posedge clk); #1;
        a_if.req_valid = 1'b0;
        a_if.req_write = 1'($urandom); a_if.req_addr = 9'($urandom); a_if.req_wdata = 8'($urandom);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (a_if.PSEL != '0) begin
                selc++; sel |= a_if.PSEL;
                if (a_if.PADDR !== addr || a_if.PWRITE !== wr || a_if.PWDATA !== wd) bad_hold++;
            end
            if (a_if.PENABLE) acc++;
            if (a_if.rsp_valid) begin
                lat = n; err = a_if.rsp_err; rd = a_if.rsp_rdata;
                break;
            end
        end
    endtask

    task automatic b_xfer(input bit wr, input logic [9:0] addr, input logic [2:0] slverr,
                          input logic [23:0] prd, output int lat, output logic [2:0] sel,
                          output bit err, output logic [7:0] rd, output logic rdy1);
        lat = -1; sel = '0; err = 1'b0; rd = '0; rdy1 = 1'bx;
        @(negedge clk);
        b_if.PSLVERR = slverr; b_if.PRDATA = prd;
        b_if.req_valid = 1'b1; b_if.req_write = wr; b_if.req_addr = addr; b_if.req_wdata = 8'($urandom);
        @(posedge clk); #1;
        b_if.req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) rdy1 = b_if.req_ready;
            sel |= b_if.PSEL;
            if (b_if.rsp_valid) begin
                lat = n; err = b_if.rsp_err; rd = b_if.rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_a: got %b want 1", a_if.req_ready); end
        checks++; if (b_if.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_b: got %b want 1", b_if.req_ready); end
        checks++; if ({a_if.PSEL, a_if.PENABLE, a_if.PWRITE, a_if.rsp_valid, a_if.rsp_err} !== 6'b0) begin
            failures++; $display("FAIL reset_ctl_a: got %b want 000000", {a_if.PSEL, a_if.PENABLE, a_if.PWRITE, a_if.rsp_valid, a_if.rsp_err}); end
        checks++; if ({a_if.PADDR, a_if.PWDATA, a_if.rsp_rdata} !== 25'b0) begin
            failures++; $display("FAIL reset_data_a: got %h want 0", {a_if.PADDR, a_if.PWDATA, a_if.rsp_rdata}); end
        checks++; if ({b_if.PSEL, b_if.PENABLE, b_if.rsp_valid} !== 5'b0) begin
            failures++; $display("FAIL reset_ctl_b: got %b want 00000", {b_if.PSEL, b_if.PENABLE, b_if.rsp_valid}); end
    endtask

    task automatic test_legacy_write();
        int lat, acc, selc, bh; logic [1:0] sel; bit err; logic [7:0] rd;
        a_xfer(1'b1, 9'h003, 8'h06, 0, 1'b0, 16'h0000, lat, acc, selc, sel, err, rd, bh);
        checks++; if (lat !== 3) begin failures++; $display("FAIL legacy_lat: got %0d want 3", lat); end
        checks++; if (selc !== 2 || sel !== 2'b01) begin failures++; $display("FAIL legacy_psel: got %b x%0d want 01 x2", sel, selc); end
        checks++; if (acc !== 1) begin failures++; $display("FAIL legacy_penable: got %0d want 1", acc); end
        checks++; if (err !== 1'b0 || bh !== 0) begin failures++; $display("FAIL legacy_err_hold: got err=%b hold=%0d want 0 0", err, bh); end
    endtask

    task automatic test_wait_read();
        int lat, acc, selc, bh; logic [1:0] sel; bit err; logic [7:0] rd;
        a_xfer(1'b0, 9'h105, 8'h00, 3, 1'b0, 16'h05A7, lat, acc, selc, sel, err, rd, bh);
        checks++; if (sel !== 2'b10) begin failures++; $display("FAIL wait_psel: got %b want 10", sel); end
        checks++; if (acc !== 4) begin failures++; $display("FAIL wait_access: got %0d want 4", acc); end
        checks++; if (rd !== 8'h05 || err !== 1'b0) begin failures++; $display("FAIL wait_rdata: got %h/%b want 05/0", rd, err); end
        checks++; if (lat !== 6) begin failures++; $display("FAIL wait_lat: got %0d want 6", lat); end
    endtask

    task automatic test_timeout();
        int lat, acc, selc, bh; logic [1:0] sel; bit err; logic [7:0] rd;
        a_xfer(1'b0, 9'h000, 8'h00, 99, 1'b0, 16'hFFFF, lat, acc, selc, sel, err, rd, bh);
        checks++; if (acc !== 4) begin failures++; $display("FAIL timeout_access: got %0d want 4", acc); end
        checks++; if (err !== 1'b1 || rd !== 8'h00) begin failures++; $display("FAIL timeout_rsp: got %b/%h want 1/00", err, rd); end
        checks++; if (a_if.req_ready !== 1'b1 || a_if.PSEL !== 2'b00) begin
            failures++; $display("FAIL timeout_idle: got ready=%b psel=%b want 1 00", a_if.req_ready, a_if.PSEL); end
    endtask

    task automatic test_random_a();
        int lat, acc, selc, bh, elat, eacc; logic [1:0] sel, esel; bit err, eerr; logic [7:0] rd, erd;
        bit wr, e; logic [8:0] addr; logic [7:0] wd; logic [15:0] prd; int w;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom); addr = 9'($urandom); wd = 8'($urandom); prd = 16'($urandom);
            w = $urandom_range(0, 5); e = ($urandom_range(0, 3) == 0);
            model_a(wr, addr, w, e, prd, elat, eacc, esel, eerr, erd);
            a_xfer(wr, addr, wd, w, e, prd, lat, acc, selc, sel, err, rd, bh);
            checks++; if (lat !== elat || acc !== eacc) begin
                failures++; $display("FAIL rand_a[%0d] timing: got lat=%0d acc=%0d want %0d %0d", i, lat, acc, elat, eacc); end
            checks++; if (sel !== esel || selc !== eacc + 1) begin
                failures++; $display("FAIL rand_a[%0d] psel: got %b x%0d want %b x%0d", i, sel, selc, esel, eacc + 1); end
            checks++; if (err !== eerr || rd !== erd) begin
                failures++; $display("FAIL rand_a[%0d] rsp: got %b/%h want %b/%h", i, err, rd, eerr, erd); end
            checks++; if (bh !== 0) begin failures++; $display("FAIL rand_a[%0d] hold: got %0d unstable cycles want 0", i, bh); end
        end
    endtask

    task automatic test_back_to_back();
        int sent, gap, en_bad, addr_bad, err_bad; int tags[$]; bit acc_now;
        sent = 0; gap = 0; en_bad = 0; addr_bad = 0; err_bad = 0;
        a_wait = 0; a_err = 1'b0;
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_addr = 9'h000; a_if.req_wdata = 8'h10;
        for (int t = 1; t <= 30 && tags.size() < 4; t++) begin
            #2 acc_now = a_if.req_valid && a_if.req_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                sent++;
                if (sent < 4) begin a_if.req_addr = 9'(sent); a_if.req_wdata = 8'(16 + sent); end
                else a_if.req_valid = 1'b0;
            end
            @(negedge clk);
            if (t <= 8) begin
                if (a_if.PSEL == '0) gap++;
                if (a_if.PENABLE !== 1'(t % 2 == 0)) en_bad++;
                if (a_if.PENABLE && a_if.PADDR !== 9'(t / 2 - 1)) addr_bad++;
            end
            if (a_if.rsp_valid) begin
                tags.push_back(t);
                if (a_if.rsp_err) err_bad++;
            end
        end
        a_if.req_valid = 1'b0;
        checks++; if (tags.size() !== 4) begin failures++; $display("FAIL b2b_count: got %0d want 4", tags.size()); end
        for (int k = 0; k < tags.size(); k++) begin
            checks++; if (tags[k] !== 3 + 2 * k) begin failures++; $display("FAIL b2b_rsp%0d: got cycle %0d want %0d", k, tags[k], 3 + 2 * k); end
        end
        checks++; if (gap !== 0 || en_bad !== 0) begin failures++; $display("FAIL b2b_phase: got gaps=%0d bad_en=%0d want 0 0", gap, en_bad); end
        checks++; if (addr_bad !== 0 || err_bad !== 0) begin failures++; $display("FAIL b2b_addr_err: got %0d/%0d want 0/0", addr_bad, err_bad); end
    endtask

    task automatic test_decode();
        int lat, elat, idx; logic [2:0] sel, esel; bit err, eerr; logic [7:0] rd, erd; logic rdy1;
        bit wr, oor; logic [9:0] addr; logic [2:0] se; logic [23:0] prd;
        b_xfer(1'b1, 10'h3FF, 3'b000, 24'h0, lat, sel, err, rd, rdy1);
        checks++; if (sel !== 3'b000 || lat !== 2) begin failures++; $display("FAIL derr: got psel=%b lat=%0d want 000 2", sel, lat); end
        checks++; if (err !== 1'b1 || rdy1 !== 1'b0) begin failures++; $display("FAIL derr_rsp: got err=%b ready=%b want 1 0", err, rdy1); end
        b_xfer(1'b0, 10'h2AA, 3'b100, 24'h123456, lat, sel, err, rd, rdy1);
        checks++; if (sel !== 3'b100 || err !== 1'b1 || rd !== 8'h00) begin
            failures++; $display("FAIL slverr2: got %b/%b/%h want 100/1/00", sel, err, rd); end
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom); addr = 10'($urandom); se = 3'($urandom); prd = 24'($urandom);
            idx = int'(addr >> 8); oor = (idx >= 3);
            elat = oor ? 2 : 3;
            esel = oor ? 3'b000 : 3'(1 << idx);
            eerr = oor ? 1'b1 : se[idx % 3];
            erd  = (!oor && !wr && !se[idx % 3]) ? prd[(idx % 3)*8 +: 8] : 8'h00;
            b_xfer(wr, addr, se, prd, lat, sel, err, rd, rdy1);
            checks++; if (lat !== elat || sel !== esel) begin
                failures++; $display("FAIL rand_b[%0d] seq: got lat=%0d psel=%b want %0d %b", i, lat, sel, elat, esel); end
            checks++; if (err !== eerr || rd !== erd) begin
                failures++; $display("FAIL rand_b[%0d] rsp: got %b/%h want %b/%h", i, err, rd, eerr, erd); end
        end
    endtask

    task automatic test_reset_mid();
        int stray, lat, acc, selc, bh; logic [1:0] sel; bit err; logic [7:0] rd;
        stray = 0;
        @(negedge clk);
        a_wait = 99; a_err = 1'b0;
        a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_addr = 9'h010; a_if.req_wdata = 8'h3C;
        @(posedge clk); #1 a_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_if.PSEL !== 2'b01 || a_if.PENABLE !== 1'b1) begin
            failures++; $display("FAIL mid_access: got psel=%b en=%b want 01 1", a_if.PSEL, a_if.PENABLE); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_if.PSEL !== 2'b00 || a_if.PENABLE !== 1'b0 || a_if.PADDR !== 9'h0) begin
            failures++; $display("FAIL mid_async: got psel=%b en=%b addr=%h want 00 0 000", a_if.PSEL, a_if.PENABLE, a_if.PADDR); end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (a_if.rsp_valid) stray++;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL mid_no_rsp: got %0d responses want 0", stray); end
        a_xfer(1'b0, 9'h1F0, 8'h00, 1, 1'b0, 16'h9900, lat, acc, selc, sel, err, rd, bh);
        checks++; if (lat !== 4 || rd !== 8'h99 || err !== 1'b0) begin
            failures++; $display("FAIL mid_recover: got lat=%0d rd=%h err=%b want 4 99 0", lat, rd, err); end
    endtask

    initial begin
        checks = 0; failures = 0;
        a_wait = 0; a_err = 1'b0; a_acnt = 0;
        a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0; a_if.PRDATA = '0;
        b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0; b_if.PRDATA = '0;
        b_if.PREADY = 3'b111; b_if.PSLVERR = 3'b000;
        test_reset();
        test_legacy_write();
        test_wait_read();
        test_timeout();
        test_random_a();
        test_back_to_back();
        test_decode();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
